// File: rtl/seq_detect_param.sv
// Serial pattern detector: compares the last PAT_W accepted bits against a
// runtime-loadable pattern, with overlap/non-overlap modes and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned        PAT_W       = 3,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [PAT_W-1:0]   RST_PATTERN = PAT_W'(3'b101),
  parameter logic               RST_OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_valid,
  input  logic             data_in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             clear,
  output logic             sequence_detected,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic [1:0]       state
);

  localparam int unsigned        FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_ARMED   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic               ovl_q, ovl_d;
  logic               det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic [PAT_W-1:0]   hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PATTERN;
      ovl_q   <= RST_OVERLAP;
      det_q   <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state: cfg_load has priority and swallows any bit on the same edge
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    ovl_d      = ovl_q;
    det_d      = 1'b0;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    match      = 1'b0;
    hist_shift = {hist_q[PAT_W-2:0], data_in};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

    if (cfg_load) begin
      pat_d   = cfg_pattern;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_EMPTY;
    end else if (data_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      match  = (fill_inc == FILL_FULL) && (hist_shift == pat_q);
      case (state_q)
        ST_EMPTY,
        ST_FILLING: state_d = (fill_inc == FILL_FULL) ? ST_ARMED : ST_FILLING;
        ST_ARMED:   state_d = ST_ARMED;
        default:    state_d = ST_EMPTY;
      endcase
      // Non-overlap: stale history stays in place but is ignored until refilled
      if (match && !ovl_q) begin
        fill_d  = '0;
        state_d = ST_EMPTY;
      end
    end

    det_d = match;

    // Clear wins over a coincident match
    if (clear) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      sat_d = sat_q | (cnt_d == CNT_MAX);
    end
  end

  assign sequence_detected = det_q;
  assign match_count       = cnt_q;
  assign count_sat         = sat_q;
  assign state             = state_q;

endmodule
